// File: rtl/dsp48a1_pkg.sv
// Shared definitions for the DSP48A1 slice: OPMODE field layout, X/Z select
// codes and datapath widths.
package dsp48a1_pkg;

  localparam int P_W      = 48;
  localparam int M_W      = 36;
  localparam int OPMODE_W = 8;

  localparam int OP_X_LSB = 0;
  localparam int OP_X_W   = 2;
  localparam int OP_Z_LSB = 2;
  localparam int OP_Z_W   = 2;
  localparam int OP_CIN   = 5;
  localparam int OP_SUB   = 7;

  typedef enum logic [OP_X_W-1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } x_sel_e;

  typedef enum logic [OP_Z_W-1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } z_sel_e;

endpackage

// File: rtl/dsp_post_adder_acc_if.sv
// Operand, control and result bundle between the upstream M/C stages and the
// post-adder/accumulator.
interface dsp_post_adder_acc_if;

  logic                           CEP;
  logic                           CECARRYIN;
  logic                           CEOPMODE;
  logic [dsp48a1_pkg::OPMODE_W-1:0] OPMODE;
  logic [dsp48a1_pkg::M_W-1:0]    M;
  logic [dsp48a1_pkg::P_W-1:0]    C;
  logic [17:0]                    D;
  logic [17:0]                    A;
  logic [17:0]                    B;
  logic [dsp48a1_pkg::P_W-1:0]    PCIN;
  logic                           CARRYIN;
  logic [dsp48a1_pkg::P_W-1:0]    P;
  logic [dsp48a1_pkg::P_W-1:0]    PCOUT;
  logic                           CARRYOUT;
  logic                           CARRYOUTF;

  modport master (
    output CEP, CECARRYIN, CEOPMODE, OPMODE, M, C, D, A, B, PCIN, CARRYIN,
    input  P, PCOUT, CARRYOUT, CARRYOUTF
  );

  modport slave (
    input  CEP, CECARRYIN, CEOPMODE, OPMODE, M, C, D, A, B, PCIN, CARRYIN,
    output P, PCOUT, CARRYOUT, CARRYOUTF
  );

endinterface

// File: rtl/reg_mux_pair.sv
// Register-or-bypass primitive: optional register with clock enable, reset
// taking priority over the enable, and a bypass path when REG=0.
module reg_mux_pair #(
  parameter int    WIDTH   = 1,
  parameter int    REG     = 1,
  parameter string RSTTYPE = "SYNC"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (REG == 1) begin : g_reg
    logic [WIDTH-1:0] q_r;

    if (RSTTYPE == "SYNC") begin : g_sync
      always_ff @(posedge clk) begin
        if (rst)     q_r <= '0;
        else if (ce) q_r <= d;
      end
    end else begin : g_async
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     q_r <= '0;
        else if (ce) q_r <= d;
      end
    end

    assign q = q_r;
  end else begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, ce};
    assign q = d;
  end

endmodule

// File: rtl/dsp_post_adder_acc.sv
// DSP48A1 post-adder/accumulator: OPMODE-selected X/Z operands, add/subtract
// with carry-in, P register with feedback for multiply-accumulate.
module dsp_post_adder_acc
  import dsp48a1_pkg::*;
#(
  parameter int    PREG        = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5"
) (
  input  logic                 clk,
  input  logic                 rst,
  dsp_post_adder_acc_if.slave  bus
);

  localparam logic [1:0] CIN_OPMODE5 = 2'd1;
  localparam logic [1:0] CIN_PORT    = 2'd2;
  localparam logic [1:0] CIN_MODE    = (CARRYINSEL == "OPMODE5") ? CIN_OPMODE5 :
                                       (CARRYINSEL == "CARRYIN") ? CIN_PORT : 2'd0;

  logic [OPMODE_W-1:0] op;
  logic                cin_src;
  logic                cin;
  logic [P_W-1:0]      x_op;
  logic [P_W-1:0]      z_op;
  logic [P_W-1:0]      p_fb;
  logic [P_W-1:0]      p_q;
  logic [P_W:0]        r;
  logic                co_q;
  x_sel_e              x_sel;
  z_sel_e              z_sel;

  reg_mux_pair #(.WIDTH(OPMODE_W), .REG(OPMODEREG), .RSTTYPE("SYNC")) u_opmode_reg (
    .clk (clk),
    .rst (rst),
    .ce  (bus.CEOPMODE),
    .d   (bus.OPMODE),
    .q   (op)
  );

  always_comb begin
    cin_src = 1'b0;
    if (CIN_MODE == CIN_OPMODE5)   cin_src = op[OP_CIN];
    else if (CIN_MODE == CIN_PORT) cin_src = bus.CARRYIN;
  end

  reg_mux_pair #(.WIDTH(1), .REG(CARRYINREG), .RSTTYPE("SYNC")) u_cyi_reg (
    .clk (clk),
    .rst (rst),
    .ce  (bus.CECARRYIN),
    .d   (cin_src),
    .q   (cin)
  );

  // Without a P register the feedback would be a combinational loop, so it reads as zero.
  assign p_fb  = (PREG == 1) ? p_q : '0;
  assign x_sel = x_sel_e'(op[OP_X_LSB +: OP_X_W]);
  assign z_sel = z_sel_e'(op[OP_Z_LSB +: OP_Z_W]);

  always_comb begin
    x_op = '0;
    case (x_sel)
      X_ZERO:  x_op = '0;
      X_M:     x_op = {{(P_W-M_W){1'b0}}, bus.M};
      X_P:     x_op = p_fb;
      X_DAB:   x_op = {bus.D[11:0], bus.A, bus.B};
      default: x_op = '0;
    endcase
  end

  always_comb begin
    z_op = '0;
    case (z_sel)
      Z_ZERO:  z_op = '0;
      Z_PCIN:  z_op = bus.PCIN;
      Z_P:     z_op = p_fb;
      Z_C:     z_op = bus.C;
      default: z_op = '0;
    endcase
  end

  // Bit 48 is the carry on add and the borrow on subtract.
  always_comb begin
    if (op[OP_SUB]) r = {1'b0, z_op} - ({1'b0, x_op} + {{P_W{1'b0}}, cin});
    else            r = {1'b0, z_op} + {1'b0, x_op} + {{P_W{1'b0}}, cin};
  end

  reg_mux_pair #(.WIDTH(P_W), .REG(PREG), .RSTTYPE("SYNC")) u_p_reg (
    .clk (clk),
    .rst (rst),
    .ce  (bus.CEP),
    .d   (r[P_W-1:0]),
    .q   (p_q)
  );

  reg_mux_pair #(.WIDTH(1), .REG(CARRYOUTREG), .RSTTYPE("SYNC")) u_carryout_reg (
    .clk (clk),
    .rst (rst),
    .ce  (bus.CECARRYIN),
    .d   (r[P_W]),
    .q   (co_q)
  );

  assign bus.P         = p_q;
  assign bus.PCOUT     = p_q;
  assign bus.CARRYOUT  = co_q;
  assign bus.CARRYOUTF = co_q;

  logic unused_in;
  assign unused_in = ^{bus.D[17:12], op[4], op[6], op[OP_CIN], bus.CARRYIN};

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Bench for dsp_post_adder_acc: a fully registered instance and a PREG=0
// instance share stimulus and are checked against an arithmetic model.
module tb_dsp_post_adder_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        cep, cecarryin, ceopmode, carryin;
  logic [7:0]  opmode;
  logic [35:0] m;
  logic [47:0] c, pcin;
  logic [17:0] d, a, b;

  int checks = 0;
  int errors = 0;

  // Model state of the registered instance after the most recent edge.
  logic [7:0]  op_m  = '0;
  logic        cin_m = 1'b0;
  logic [47:0] p_m   = '0;
  logic        co_m  = 1'b0;

  always #5 clk = ~clk;

  dsp_post_adder_acc_if bus1 ();
  dsp_post_adder_acc_if bus2 ();

  assign bus1.CEP = cep;       assign bus2.CEP = cep;
  assign bus1.CECARRYIN = cecarryin; assign bus2.CECARRYIN = cecarryin;
  assign bus1.CEOPMODE = ceopmode;   assign bus2.CEOPMODE = ceopmode;
  assign bus1.OPMODE = opmode; assign bus2.OPMODE = opmode;
  assign bus1.M = m;           assign bus2.M = m;
  assign bus1.C = c;           assign bus2.C = c;
  assign bus1.D = d;           assign bus2.D = d;
  assign bus1.A = a;           assign bus2.A = a;
  assign bus1.B = b;           assign bus2.B = b;
  assign bus1.PCIN = pcin;     assign bus2.PCIN = pcin;
  assign bus1.CARRYIN = carryin; assign bus2.CARRYIN = carryin;

  dsp_post_adder_acc u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  dsp_post_adder_acc #(.PREG(0), .CARRYOUTREG(0)) u_dut_comb (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Full 49-bit result for a given effective opmode, carry-in and feedback.
  function automatic logic [48:0] model_r(input logic [7:0] op, input logic ci,
                                          input logic [47:0] fb);
    longint unsigned xv, zv, mask, res;
    mask = (64'd1 << 49) - 64'd1;
    case (op[1:0])
      2'd0: xv = 0;
      2'd1: xv = longint'(m);
      2'd2: xv = longint'(fb);
      default: xv = (longint'(d[11:0]) << 36) | (longint'(a) << 18) | longint'(b);
    endcase
    case (op[3:2])
      2'd0: zv = 0;
      2'd1: zv = longint'(pcin);
      2'd2: zv = longint'(fb);
      default: zv = longint'(c);
    endcase
    if (op[7]) res = (zv - xv - longint'(ci)) & mask;
    else       res = (zv + xv + longint'(ci)) & mask;
    return res[48:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    logic [48:0] r1, r2;
    logic [7:0]  n_op;
    logic        n_cin, n_co;
    logic [47:0] n_p;
    @(posedge clk);
    r1 = model_r(op_m, cin_m, p_m);
    if (rst) begin
      n_op = '0; n_cin = 1'b0; n_p = '0; n_co = 1'b0;
    end else begin
      n_op  = ceopmode  ? opmode   : op_m;
      n_cin = cecarryin ? op_m[5]  : cin_m;
      n_p   = cep       ? r1[47:0] : p_m;
      n_co  = cecarryin ? r1[48]   : co_m;
    end
    op_m = n_op; cin_m = n_cin; p_m = n_p; co_m = n_co;
    @(negedge clk);
    r2 = model_r(op_m, cin_m, 48'd0);
    chk("p_reg",        64'(bus1.P),         64'(p_m));
    chk("pcout_reg",    64'(bus1.PCOUT),     64'(p_m));
    chk("carryout_reg", 64'(bus1.CARRYOUT),  64'(co_m));
    chk("carryoutf_reg",64'(bus1.CARRYOUTF), 64'(co_m));
    chk("p_comb",        64'(bus2.P),         64'(r2[47:0]));
    chk("pcout_comb",    64'(bus2.PCOUT),     64'(r2[47:0]));
    chk("carryout_comb", 64'(bus2.CARRYOUT),  64'(r2[48]));
    chk("carryoutf_comb",64'(bus2.CARRYOUTF), 64'(r2[48]));
  endtask

  task automatic drive(input logic [7:0] op, input logic [35:0] mv, input logic [47:0] cv);
    rst = 1'b0; cep = 1'b1; cecarryin = 1'b1; ceopmode = 1'b1;
    opmode = op; m = mv; c = cv;
  endtask

  initial begin
    rst = 1'b1; cep = 1'b1; cecarryin = 1'b1; ceopmode = 1'b1; carryin = 1'b0;
    opmode = '0; m = '0; c = '0; d = '0; a = '0; b = '0; pcin = '0;

    step(); step();
    chk("reset_p", 64'(bus1.P), 64'd0);
    chk("reset_co", 64'(bus1.CARRYOUT), 64'd0);

    drive(8'h0D, 36'd100, 48'd5);
    step(); step();
    chk("madd_p", 64'(bus1.P), 64'd105);
    chk("madd_co", 64'(bus1.CARRYOUT), 64'd0);

    drive(8'h09, 36'd3, 48'd0);
    rst = 1'b1; step();
    rst = 1'b0; step();
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("acc_p", 64'(bus1.P), 64'(3 * i));
    end
    cep = 1'b0; step(); step();
    chk("acc_hold", 64'(bus1.P), 64'd12);
    cep = 1'b1; rst = 1'b1; step();
    chk("acc_rst", 64'(bus1.P), 64'd0);
    rst = 1'b0; step(); step();
    chk("acc_after_rst", 64'(bus1.P), 64'd3);

    drive(8'h8D, 36'd20, 48'd10);
    step(); step();
    chk("sub_p", 64'(bus1.P), 64'hFFFF_FFFF_FFF6);
    chk("sub_borrow", 64'(bus1.CARRYOUT), 64'd1);

    drive(8'h0D, 36'd1, 48'hFFFF_FFFF_FFFF);
    step(); step();
    chk("wrap_p", 64'(bus1.P), 64'd0);
    chk("wrap_co", 64'(bus1.CARRYOUT), 64'd1);
    drive(8'h2D, 36'd0, 48'd0);
    step(); step(); step();
    chk("cin_p", 64'(bus1.P), 64'd1);

    drive(8'h0E, 36'd0, 48'd7);
    rst = 1'b1; step();
    rst = 1'b0; step();
    chk("comb_p", 64'(bus2.P), 64'd7);
    chk("comb_known", 64'($isunknown(bus2.P)), 64'd0);

    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 31) == 0);
      cep       = ($urandom_range(0, 4) != 0);
      cecarryin = ($urandom_range(0, 4) != 0);
      ceopmode  = ($urandom_range(0, 3) != 0);
      carryin   = 1'($urandom);
      opmode    = 8'($urandom);
      m         = {4'($urandom), 32'($urandom)};
      c         = ($urandom_range(0, 3) == 0) ? 48'hFFFF_FFFF_FFFF : {16'($urandom), 32'($urandom)};
      pcin      = {16'($urandom), 32'($urandom)};
      d         = 18'($urandom);
      a         = 18'($urandom);
      b         = 18'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
